// File: rtl/branch_predict_unit.sv
// Branch direction predictor: PC-indexed table of saturating counters, read in IF and
// trained in EX, with misprediction detection, recovery PC and saturating statistics.
module branch_predict_unit #(
  parameter int PC_W       = 32,
  parameter int IDX_W      = 6,
  parameter int CNT_W      = 2,
  parameter int TARGET_CHK = 1,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken_if,
  input  logic              ex_en,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  input  logic [PC_W-1:0]   ex_target,
  output logic              miss,
  output logic [PC_W-1:0]   recovery_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int INIT_I  = (1 << (CNT_W - 1)) - 1;
  localparam logic [CNT_W-1:0] CNT_INIT = INIT_I[CNT_W-1:0];

  function automatic logic [CNT_W-1:0] cnt_train(input logic [CNT_W-1:0] c, input logic up);
    if (up)
      cnt_train = (&c) ? c : c + CNT_W'(1);
    else
      cnt_train = (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    stat_inc = (&v) ? v : v + STAT_W'(1);
  endfunction

  logic [CNT_W-1:0]  tbl_q [ENTRIES];
  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic [CNT_W-1:0]  tbl_upd_d;
  logic [STAT_W-1:0] br_count_q, br_count_d;
  logic [STAT_W-1:0] miss_count_q, miss_count_d;
  logic              dir_miss;
  logic              tgt_miss;
  logic              unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc, ex_pc};

  // IF: zero-latency read of the registered table, no bypass from a same-cycle update
  assign pred_taken_if = tbl_q[if_idx][CNT_W-1];

  // EX: miss detection and recovery address
  assign dir_miss    = (ex_pred_taken != ex_taken);
  assign tgt_miss    = (TARGET_CHK != 0) && ex_taken && ex_pred_taken &&
                       (ex_pred_target != ex_target);
  assign miss        = ex_en && (dir_miss || tgt_miss);
  assign recovery_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);

  always_comb begin
    tbl_upd_d    = cnt_train(tbl_q[ex_idx], ex_taken);
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (ex_en) begin
      br_count_d = stat_inc(br_count_q);
      if (miss)
        miss_count_d = stat_inc(miss_count_q);
    end
  end

  // Training and statistics; reset wins over a concurrent update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl_q[i] <= CNT_INIT;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      if (ex_en)
        tbl_q[ex_idx] <= tbl_upd_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign br_count   = br_count_q;
  assign miss_count = miss_count_q;

endmodule
